peripheral_arbiter_wb: RTL and testbench

- Round-robin Wishbone B3 arbiter that shares the single SPRAM slave port between NM bus masters (CPU cores, DMA).
- Sits between the master-side crossbar and the SPRAM Wishbone wrapper.
- A granted master owns the slave for its whole cycle (cyc held high), including classic and incrementing bursts.
- A watchdog terminates a stalled transfer with err so a dead slave cannot hang the MPSoC.

---
 rtl/peripheral_bb_pkg.sv | 20 ++
 rtl/peripheral_arbiter_rr.sv | 29 ++
 rtl/peripheral_arbiter_wb.sv | 157 +++++++++++++++
 tb/tb_peripheral_arbiter_wb.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_bb_pkg.sv
// Shared Wishbone bus constants and the arbiter FSM state type for the
// peripheral building-block slice.
package peripheral_bb_pkg;

    localparam int AW = 32;
    localparam int DW = 32;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_ABORT = 2'd2
    } arb_state_e;

endpackage

// File: rtl/peripheral_arbiter_rr.sv
// Combinational round-robin priority encoder: returns a one-hot grant for the
// first requester at or above ptr, wrapping modulo NM.
module peripheral_arbiter_rr #(
    parameter int NM = 4,
    parameter int IW = (NM > 1) ? $clog2(NM) : 1
) (
    input  logic [NM-1:0] req,
    input  logic [IW-1:0] ptr,
    output logic [NM-1:0] grant,
    output logic [IW-1:0] idx
);

    always_comb begin
        logic [IW-1:0] k;
        k     = '0;
        grant = '0;
        idx   = '0;
        // Walk from farthest to nearest so the nearest requester is written last.
        for (int i = NM - 1; i >= 0; i--) begin
            k = IW'((int'(ptr) + i) % NM);
            if (req[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/peripheral_arbiter_wb.sv
// Round-robin Wishbone B3 arbiter sharing one SPRAM slave port between NM
// masters, with a watchdog that terminates stalled transfers with err.
module peripheral_arbiter_wb #(
    parameter int NM      = 4,
    parameter int AW      = peripheral_bb_pkg::AW,
    parameter int DW      = peripheral_bb_pkg::DW,
    parameter int TIMEOUT = 255
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic [NM*AW-1:0]       m_adr_i,
    input  logic [NM*DW-1:0]       m_dat_i,
    input  logic [NM*(DW/8)-1:0]   m_sel_i,
    input  logic [NM-1:0]          m_we_i,
    input  logic [NM-1:0]          m_cyc_i,
    input  logic [NM-1:0]          m_stb_i,
    input  logic [NM*3-1:0]        m_cti_i,
    input  logic [NM*2-1:0]        m_bte_i,
    output logic [DW-1:0]          m_dat_o,
    output logic [NM-1:0]          m_ack_o,
    output logic [NM-1:0]          m_err_o,
    output logic [AW-1:0]          s_adr_o,
    output logic [DW-1:0]          s_dat_o,
    output logic [DW/8-1:0]        s_sel_o,
    output logic                   s_we_o,
    output logic [2:0]             s_cti_o,
    output logic [1:0]             s_bte_o,
    output logic                   s_cyc_o,
    output logic                   s_stb_o,
    input  logic [DW-1:0]          s_dat_i,
    input  logic                   s_ack_i,
    input  logic                   s_err_i
);

    import peripheral_bb_pkg::*;

    localparam int IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit WD_EN = (TIMEOUT > 0);
    localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);

    arb_state_e    state;
    logic [NM-1:0] grant;
    logic [NM-1:0] rr_grant;
    logic [IW-1:0] gidx;
    logic [IW-1:0] rr_idx;
    logic [IW-1:0] ptr;
    logic [IW-1:0] ptr_next;
    logic [CW-1:0] wd_cnt;
    logic          busy;
    logic          cyc_g;
    logic          stb_g;
    logic          stall;
    logic          wd_fire;

    peripheral_arbiter_rr #(
        .NM (NM),
        .IW (IW)
    ) u_rr (
        .req   (m_cyc_i),
        .ptr   (ptr),
        .grant (rr_grant),
        .idx   (rr_idx)
    );

    assign busy     = (state == ARB_BUSY);
    assign cyc_g    = |(m_cyc_i & grant);
    assign stb_g    = |(m_stb_i & grant);
    assign stall    = busy & cyc_g & stb_g & ~s_ack_i & ~s_err_i;
    // Firing on the stalled cycle where the count would reach TIMEOUT lets a
    // same-cycle ack win, because that cycle is then not a stall.
    assign wd_fire  = WD_EN & stall & (wd_cnt == WD_LAST);
    assign ptr_next = (gidx == IW'(NM - 1)) ? '0 : gidx + IW'(1);

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_dat_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        if (busy) begin
            s_cyc_o = cyc_g;
            s_stb_o = stb_g;
            m_dat_o = s_dat_i;
            for (int k = 0; k < NM; k++) begin
                if (grant[k]) begin
                    s_adr_o    = m_adr_i[k*AW +: AW];
                    s_dat_o    = m_dat_i[k*DW +: DW];
                    s_sel_o    = m_sel_i[k*(DW/8) +: DW/8];
                    s_we_o     = m_we_i[k];
                    s_cti_o    = m_cti_i[k*3 +: 3];
                    s_bte_o    = m_bte_i[k*2 +: 2];
                    m_ack_o[k] = s_ack_i;
                    m_err_o[k] = s_err_i | wd_fire;
                end
            end
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            gidx   <= '0;
            ptr    <= '0;
            wd_cnt <= '0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    wd_cnt <= '0;
                    if (|m_cyc_i) begin
                        grant <= rr_grant;
                        gidx  <= rr_idx;
                        state <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (!cyc_g) begin
                        state  <= ARB_IDLE;
                        grant  <= '0;
                        ptr    <= ptr_next;
                        wd_cnt <= '0;
                    end else if (wd_fire) begin
                        state  <= ARB_ABORT;
                        wd_cnt <= '0;
                    end else if (stall) begin
                        if (wd_cnt != WD_MAX) begin
                            wd_cnt <= wd_cnt + CW'(1);
                        end
                    end else begin
                        wd_cnt <= '0;
                    end
                end
                ARB_ABORT: begin
                    // Grant is kept so the aborted master's cyc can be watched.
                    if (!cyc_g) begin
                        state <= ARB_IDLE;
                        grant <= '0;
                        ptr   <= ptr_next;
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_peripheral_arbiter_wb.sv
// Scoreboard bench for peripheral_arbiter_wb: directed master transactions,
// a simple latency-configurable slave, and a monitor checking every ack/err.
module tb_peripheral_arbiter_wb;

    localparam int NM = 4;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NM*32-1:0] m_adr;
    logic [NM*32-1:0] m_wdat;
    logic [NM*4-1:0]  m_sel;
    logic [NM-1:0]    m_we;
    logic [NM-1:0]    m_cyc;
    logic [NM-1:0]    m_stb;
    logic [NM*3-1:0]  m_cti;
    logic [NM*2-1:0]  m_bte;
    logic [31:0]      m_dat;
    logic [NM-1:0]    m_ack;
    logic [NM-1:0]    m_err;
    logic [31:0]      s_adr;
    logic [31:0]      s_wdat;
    logic [3:0]       s_sel;
    logic             s_we;
    logic [2:0]       s_cti;
    logic [1:0]       s_bte;
    logic             s_cyc;
    logic             s_stb;
    logic [31:0]      s_rdat;
    logic             s_ack;
    logic             s_err;

    peripheral_arbiter_wb #(.NM(NM), .AW(32), .DW(32), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),    .wb_rst_ni (rst_n),
        .m_adr_i  (m_adr),  .m_dat_i   (m_wdat), .m_sel_i (m_sel),
        .m_we_i   (m_we),   .m_cyc_i   (m_cyc),  .m_stb_i (m_stb),
        .m_cti_i  (m_cti),  .m_bte_i   (m_bte),
        .m_dat_o  (m_dat),  .m_ack_o   (m_ack),  .m_err_o (m_err),
        .s_adr_o  (s_adr),  .s_dat_o   (s_wdat), .s_sel_o (s_sel),
        .s_we_o   (s_we),   .s_cti_o   (s_cti),  .s_bte_o (s_bte),
        .s_cyc_o  (s_cyc),  .s_stb_o   (s_stb),
        .s_dat_i  (s_rdat), .s_ack_i   (s_ack),  .s_err_i (s_err)
    );

    always #5 clk = ~clk;

    // Slave model: acks after `lat` wait cycles of stb, never when no_ack.
    logic [31:0]  mem [0:255];
    logic [255:0] written;
    int unsigned  wcnt;
    int unsigned  lat;
    bit           no_ack;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt    <= 0;
            written <= '0;
        end else begin
            if (s_cyc && s_stb && !s_ack) wcnt <= wcnt + 1;
            else                          wcnt <= 0;
            if (s_ack && s_we) begin
                mem[s_adr[9:2]]     <= s_wdat;
                written[s_adr[9:2]] <= 1'b1;
            end
        end
    end

    assign s_ack  = s_cyc & s_stb & ~no_ack & (wcnt >= lat);
    assign s_err  = 1'b0;
    assign s_rdat = written[s_adr[9:2]] ? mem[s_adr[9:2]] : ~s_adr;

    typedef struct {
        logic [3:0]  ack;
        logic [3:0]  err;
        bit          chk_dat;
        logic [31:0] dat;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input logic [3:0] e, input bit cd, input logic [31:0] d);
        exp_t x;
        x.ack = a; x.err = e; x.chk_dat = cd; x.dat = d;
        sb_q.push_back(x);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (rst_n && ((|m_ack) || (|m_err))) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_term", {m_err, m_ack}, 8'h00);
            end else begin
                x = sb_q.pop_front();
                chk("sb_ack", m_ack, x.ack);
                chk("sb_err", m_err, x.err);
                if (x.chk_dat) chk("sb_rdata", m_dat, x.dat);
            end
        end
    end

    task automatic set_req(input int k, input bit we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [2:0] cti);
        m_adr[k*32 +: 32] = adr;
        m_wdat[k*32 +: 32] = dat;
        m_sel[k*4 +: 4]   = 4'hF;
        m_we[k]           = we;
        m_cti[k*3 +: 3]   = cti;
        m_bte[k*2 +: 2]   = peripheral_bb_pkg::BTE_LINEAR;
        m_cyc[k]          = 1'b1;
        m_stb[k]          = 1'b1;
    endtask

    task automatic drop(input int k);
        m_cyc[k]        = 1'b0;
        m_stb[k]        = 1'b0;
        m_we[k]         = 1'b0;
        m_cti[k*3 +: 3] = 3'b000;
    endtask

    task automatic wait_term(input int k);
        int n;
        n = 0;
        @(negedge clk);
        while (!(m_ack[k] || m_err[k]) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!(m_ack[k] || m_err[k])) begin
            n_chk++;
            n_fail++;
            $display("FAIL term_wait_m%0d: no ack/err within 100 cycles", k);
        end
    endtask

    task automatic xact(input int k);
        wait_term(k);
        @(posedge clk); #1;
        drop(k);
    endtask

    task automatic burst(input int k, input logic [31:0] base, input int n);
        logic [2:0] c;
        for (int i = 0; i < n; i++) begin
            c = (i == n - 1) ? peripheral_bb_pkg::CTI_EOB : peripheral_bb_pkg::CTI_INCR;
            set_req(k, 1'b1, base + 32'(4 * i), 32'hB000_0000 + 32'(i), c);
            wait_term(k);
            chk($sformatf("burst_cti_beat%0d", i), s_cti, c);
            @(posedge clk); #1;
        end
        drop(k);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int stalls;
        int n;
        logic [31:0] a;
        rst_n = 1'b0;
        m_adr = '0; m_wdat = '0; m_sel = '0; m_we = '0;
        m_cyc = '0; m_stb = '0; m_cti = '0; m_bte = '0;
        lat = 2; no_ack = 1'b0;

        // Reset: outputs stay 0 even with a master requesting.
        set_req(1, 1'b1, 32'h44, 32'h1234_5678, peripheral_bb_pkg::CTI_CLASSIC);
        repeat (2) @(negedge clk);
        chk("reset_outputs", {s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel, s_cti, s_bte,
                              m_ack, m_err, m_dat}, '0);
        drop(1);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write by master 0, then read back.
        push(4'b0001, 4'b0000, 1'b0, 32'h0);
        set_req(0, 1'b1, 32'h10, 32'hDEAD_BEEF, peripheral_bb_pkg::CTI_CLASSIC);
        @(negedge clk);
        chk("t1_cyc_arb_cycle", s_cyc, 1'b0);
        @(negedge clk);
        chk("t1_cyc_granted", s_cyc, 1'b1);
        chk("t1_req_fields", {s_adr, s_wdat, s_we, s_sel}, {32'h10, 32'hDEAD_BEEF, 1'b1, 4'hF});
        xact(0);
        @(posedge clk); #1;
        push(4'b0001, 4'b0000, 1'b1, 32'hDEAD_BEEF);
        set_req(0, 1'b0, 32'h10, 32'h0, peripheral_bb_pkg::CTI_CLASSIC);
        xact(0);

        // All four masters hold cyc from reset release.
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int k = 0; k < NM; k++) begin
            a = 32'h100 + 32'(16 * k);
            set_req(k, 1'b0, a, 32'h0, peripheral_bb_pkg::CTI_CLASSIC);
            push(4'(1 << k), 4'b0000, 1'b1, ~a);
        end
        @(negedge clk); rst_n = 1'b1;
        fork
            xact(0);
            xact(1);
            xact(2);
            xact(3);
        join

        // 8-beat INCR burst by master 2 while master 1 requests.
        @(posedge clk); #1;
        lat = 0;
        for (int i = 0; i < 8; i++) push(4'b0100, 4'b0000, 1'b0, 32'h0);
        push(4'b0010, 4'b0000, 1'b1, 32'hB000_0001);
        fork
            burst(2, 32'h200, 8);
            begin
                int w;
                w = 0;
                @(negedge clk);
                while (!s_cyc && w < 50) begin
                    @(negedge clk);
                    w++;
                end
                @(posedge clk); #1;
                set_req(1, 1'b0, 32'h204, 32'h0, peripheral_bb_pkg::CTI_CLASSIC);
                xact(1);
            end
        join

        // Watchdog: slave never acks master 3.
        @(posedge clk); #1;
        no_ack = 1'b1;
        push(4'b0000, 4'b1000, 1'b0, 32'h0);
        push(4'b0001, 4'b0000, 1'b1, ~32'h180);
        set_req(3, 1'b0, 32'h300, 32'h0, peripheral_bb_pkg::CTI_CLASSIC);
        stalls = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (s_cyc && s_stb) stalls++;
        end while (!m_err[3] && n < 40);
        chk("t5_err_on_stalled_cycle", stalls, TO);
        @(posedge clk); #1;
        set_req(0, 1'b0, 32'h180, 32'h0, peripheral_bb_pkg::CTI_CLASSIC);
        @(negedge clk);
        chk("t5_abort_outputs", {s_cyc, s_stb, m_err, m_ack}, '0);
        no_ack = 1'b0;
        lat = 2;
        @(posedge clk); #1;
        drop(3);
        xact(0);

        // Ack on the cycle the watchdog would expire.
        @(posedge clk); #1;
        lat = TO - 1;
        push(4'b0010, 4'b0000, 1'b1, ~32'h340);
        set_req(1, 1'b0, 32'h340, 32'h0, peripheral_bb_pkg::CTI_CLASSIC);
        stalls = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (s_cyc && s_stb) stalls++;
        end while (!(m_ack[1] || m_err[1]) && n < 40);
        chk("t6_ack_cycle", stalls, TO);
        chk("t6_no_err", m_err, 4'b0000);
        @(posedge clk); #1;
        drop(1);

        // Asynchronous reset in the middle of a burst.
        @(posedge clk); #1;
        lat = 2;
        no_ack = 1'b1;
        set_req(2, 1'b1, 32'h240, 32'hCAFE_0000, peripheral_bb_pkg::CTI_INCR);
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_async_reset_outputs", {s_cyc, s_stb, s_we, s_adr, s_wdat, s_sel, s_cti, s_bte,
                                       m_ack, m_err, m_dat}, '0);
        set_req(0, 1'b0, 32'h180, 32'h0, peripheral_bb_pkg::CTI_CLASSIC);
        set_req(2, 1'b0, 32'h184, 32'h0, peripheral_bb_pkg::CTI_CLASSIC);
        no_ack = 1'b0;
        push(4'b0001, 4'b0000, 1'b1, ~32'h180);
        push(4'b0100, 4'b0000, 1'b1, ~32'h184);
        @(negedge clk); rst_n = 1'b1;
        fork
            xact(0);
            xact(2);
        join

        n = 0;
        while (sb_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sb_drained", sb_q.size(), 0);
        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
